reg_view_monitor: RTL and testbench
===================================

// Module: reg_view_monitor
// PURPOSE
//  Parametrised register-view front end for the 6502 softcore board display.
//  Takes NUM_CH packed register channels (e.g. PC, SP, A, X, Y) and four push-buttons.
//  Debounces the buttons and cycles through channels manually or by auto-scroll.
//  Can freeze a snapshot of all channels; scans the selected value onto a
//  multiplexed hex 7-segment display. Sits between the CPU core and board LEDs.
// PARAMETERS
//  NUM_CH        5      number of channels, >=2; ch0=PC, ch1=SP, ch2=A, ch3=X, ch4=Y at top level
//  NUM_DIG       4      display digits; channel width CH_W = 4*NUM_DIG
//  DEB_CYCLES    50000  cycles a synchronised button level must be stable to be accepted
//  SCROLL_CYCLES 50e6   cycles per channel in auto-scroll mode
//  SCAN_CYCLES   50000  cycles each digit is enabled per scan step
// PORTS
//  clk      in   1             system clock
//  reset    in   1             asynchronous, active-low reset
//  regs_in  in   NUM_CH*CH_W   channel k at [k*CH_W +: CH_W]; 8-bit regs zero-extended by caller
//  btn_n    in   4             active-low, asynchronous buttons:
//                              [0]=next, [1]=prev, [2]=freeze toggle, [3]=auto-scroll toggle
//  seg      out  8             active-low segments {dp,g,f,e,d,c,b,a}
//  dig      out  NUM_DIG       active-low digit enables; one-hot-low while scanning
//  sel_ch   out  clog2(NUM_CH) currently selected channel index
//  frozen   out  1             1 = display shows snapshot, not live data
//  auto_on  out  1             1 = auto-scroll active
// BEHAVIOUR
//  Reset (reset=0, async): sel_ch=0, frozen=0, auto_on=0, snapshot=0, all timers=0.
//  Reset outputs: seg=8'hFF, dig=all 1s (blank); all debounced states = released.
//  Input path: 2-FF synchroniser per button.
//  - Debounced state changes only after DEB_CYCLES consecutive cycles of the new level.
//  - A pressed-edge of the debounced state gives a 1-cycle press pulse; release gives no pulse.
//  Channel select (press pulse in cycle t -> sel_ch updated at t+1):
//  - next: sel_ch+1, wraps NUM_CH-1 -> 0. prev: sel_ch-1, wraps 0 -> NUM_CH-1.
//  - next and prev pulses in the same cycle: sel_ch unchanged.
//  - Any manual next/prev clears the scroll timer.
//  Auto-scroll:
//  - auto press toggles auto_on and clears the scroll timer.
//  - While auto_on=1, the scroll timer counts 0..SCROLL_CYCLES-1; at terminal count sel_ch
//    advances as for next and the timer restarts.
//  - If a manual step and terminal count coincide, the manual step wins (single step only).
//  Freeze FSM, states LIVE and HOLD:
//  - LIVE + freeze pulse: copy the whole regs_in bus into the snapshot at that edge, go to
//    HOLD, frozen=1.
//  - HOLD + freeze pulse: go to LIVE, frozen=0.
//  - In HOLD, next/prev/auto still operate but select from the snapshot.
//  Display value: view = frozen ? snapshot[sel_ch] : regs_in[sel_ch], registered (1-cycle latency).
//  Scan:
//  - The digit index advances every SCAN_CYCLES and wraps NUM_DIG-1 -> 0.
//  - Digit d shows view[4d+3:4d] (dig[0] = least significant nibble).
//  - Standard hex font 0-F.
//  - dp is lit (0) on digit 0 iff frozen=1, and on digit NUM_DIG-1 iff auto_on=1.
//  - seg and dig are registered together, so no ghosting between digits.
//  - The first enabled digit after reset release is digit 0, one cycle after release.
//  Reset asserted mid-press or mid-scroll: everything returns to reset values immediately.
//  The button must then be re-debounced (a held button re-pulses after DEB_CYCLES once
//  released-to-pressed is seen; a button held through reset does not pulse).
// TESTING (bench params: NUM_CH=5, NUM_DIG=4, DEB_CYCLES=4, SCROLL_CYCLES=16, SCAN_CYCLES=2)
//  1. Reset, regs_in ch0=16'h1234:
//     -> seg/dig blank during reset; then digits 0..3 show 4,3,2,1 in turn, 2 cycles each.
//  2. Bounce btn_n[0] (low 2 cyc, high 1 cyc, low 10 cyc):
//     -> exactly one pulse; sel_ch 0->1. Five clean presses from 0 wrap to 0.
//     -> One prev press from 0 gives 4.
//  3. next and prev debounced-pressed in the same cycle -> sel_ch unchanged.
//  4. Toggle auto_on -> sel_ch advances every 16 cycles.
//     -> A next press at timer=10 advances once and the next auto step comes 16 cycles later.
//     -> dp lit on digit 3.
//  5. ch2=16'h00AA; freeze, then drive ch2=16'h0055:
//     -> display stays 00AA and dp lit on digit 0; unfreeze -> shows 0055 within 2 cycles.
//  6. Assert reset while btn_n[1] is held and auto_on=1:
//     -> all outputs reset; after release with button still held, no pulse occurs.

Source files
------------

// File: rtl/reg_view_if.sv
// ============================================================================
//  Module      : reg_view_if
//  Description : Register-view bus: channel data and buttons in, display out.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface reg_view_if #(
  parameter int NUM_CH  = 5,
  parameter int NUM_DIG = 4
);
  localparam int c_ch_w  = 4 * NUM_DIG;
  localparam int c_sel_w = $clog2(NUM_CH);

  logic [NUM_CH*c_ch_w-1:0] regs_in;
  logic [3:0]               btn_n;
  logic [7:0]               seg;
  logic [NUM_DIG-1:0]       dig;
  logic [c_sel_w-1:0]       sel_ch;
  logic                     frozen;
  logic                     auto_on;

  modport master (output regs_in, output btn_n,
                  input seg, input dig, input sel_ch, input frozen, input auto_on);
  modport slave  (input regs_in, input btn_n,
                  output seg, output dig, output sel_ch, output frozen, output auto_on);
endinterface

`default_nettype wire

// File: rtl/reg_view_monitor.sv
// ============================================================================
//  Module      : reg_view_monitor
//  Description : Debounced channel selector, freeze snapshot, hex 7-seg scanner.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module reg_view_monitor #(
  parameter int NUM_CH        = 5,
  parameter int NUM_DIG       = 4,
  parameter int DEB_CYCLES    = 50000,
  parameter int SCROLL_CYCLES = 50_000_000,
  parameter int SCAN_CYCLES   = 50000
) (
  input  wire logic clk,
  input  wire logic reset,
  reg_view_if.slave bus
);
  localparam int c_ch_w   = 4 * NUM_DIG;
  localparam int c_sel_w  = $clog2(NUM_CH);
  localparam int c_deb_w  = $clog2(DEB_CYCLES + 1);
  localparam int c_scr_w  = $clog2(SCROLL_CYCLES + 1);
  localparam int c_scan_w = $clog2(SCAN_CYCLES + 1);
  localparam int c_dig_w  = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

  localparam logic [c_deb_w-1:0]  c_deb_last  = c_deb_w'(DEB_CYCLES - 1);
  localparam logic [c_scr_w-1:0]  c_scr_last  = c_scr_w'(SCROLL_CYCLES - 1);
  localparam logic [c_scan_w-1:0] c_scan_last = c_scan_w'(SCAN_CYCLES - 1);
  localparam logic [c_sel_w-1:0]  c_last_ch   = c_sel_w'(NUM_CH - 1);
  localparam logic [c_dig_w-1:0]  c_dig_last  = c_dig_w'(NUM_DIG - 1);

  typedef enum logic [0:0] {LIVE = 1'b0, HOLD = 1'b1} frz_state_t;

  logic [3:0]         r_sync1, r_sync2, r_deb, r_armed, r_press;
  logic [c_deb_w-1:0] r_deb_cnt [4];

  // Synchronisers reset to the pressed level: a button held across reset
  // never arms, so it cannot pulse until it has been seen released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.btn_n;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_deb   <= '1;
      r_armed <= '0;
      r_press <= '0;
      for (int i = 0; i < 4; i++) r_deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync2[i]) r_armed[i] <= 1'b1;
        if (r_sync2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == c_deb_last) begin
          r_deb_cnt[i] <= '0;
          r_deb[i]     <= r_sync2[i];
          r_press[i]   <= ~r_sync2[i] & r_armed[i];
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic w_next, w_prev, w_frz, w_auto_p;
  assign w_next   = r_press[0];
  assign w_prev   = r_press[1];
  assign w_frz    = r_press[2];
  assign w_auto_p = r_press[3];

  logic [c_sel_w-1:0] r_sel, w_sel_nxt, w_sel_inc, w_sel_dec;
  logic [c_scr_w-1:0] r_scr;
  logic               r_auto, w_tc;

  assign w_tc      = r_auto && (r_scr == c_scr_last);
  assign w_sel_inc = (r_sel == c_last_ch) ? '0 : r_sel + 1'b1;
  assign w_sel_dec = (r_sel == '0) ? c_last_ch : r_sel - 1'b1;

  // Manual steps take priority over the scroll terminal count.
  always_comb begin
    w_sel_nxt = r_sel;
    if (w_next && !w_prev)       w_sel_nxt = w_sel_inc;
    else if (w_prev && !w_next)  w_sel_nxt = w_sel_dec;
    else if (!w_next && !w_prev && w_tc) w_sel_nxt = w_sel_inc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel  <= '0;
      r_auto <= 1'b0;
      r_scr  <= '0;
    end else begin
      r_sel <= w_sel_nxt;
      if (w_auto_p) r_auto <= ~r_auto;
      if (w_next || w_prev || w_auto_p) r_scr <= '0;
      else if (r_auto)                  r_scr <= w_tc ? '0 : r_scr + 1'b1;
      else                              r_scr <= '0;
    end
  end

  frz_state_t              r_state, w_state_nxt;
  logic                    w_snap_load;
  logic [NUM_CH*c_ch_w-1:0] r_snap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= LIVE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_snap_load = 1'b0;
    case (r_state)
      LIVE: if (w_frz) begin
        w_state_nxt = HOLD;
        w_snap_load = 1'b1;
      end
      HOLD: if (w_frz) w_state_nxt = LIVE;
      default: w_state_nxt = LIVE;
    endcase
  end

  logic [c_ch_w-1:0] r_view;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_snap <= '0;
      r_view <= '0;
    end else begin
      if (w_snap_load) r_snap <= bus.regs_in;
      r_view <= (r_state == HOLD) ? r_snap[c_ch_w*r_sel +: c_ch_w]
                                  : bus.regs_in[c_ch_w*r_sel +: c_ch_w];
    end
  end

  logic [c_scan_w-1:0] r_scan_cnt;
  logic [c_dig_w-1:0]  r_dig_idx;
  logic [3:0]          w_nib;
  logic [6:0]          w_font;
  logic                w_dp_lit;
  logic [NUM_DIG-1:0]  w_dig_oh, r_dig;
  logic [7:0]          r_seg;

  assign w_nib    = r_view[4*r_dig_idx +: 4];
  assign w_dig_oh = NUM_DIG'(1) << r_dig_idx;
  assign w_dp_lit = ((r_dig_idx == '0) && (r_state == HOLD)) ||
                    ((r_dig_idx == c_dig_last) && r_auto);

  // Active-low {g,f,e,d,c,b,a}
  always_comb begin
    w_font = 7'h7F;
    case (w_nib)
      4'h0: w_font = 7'h40;  4'h1: w_font = 7'h79;
      4'h2: w_font = 7'h24;  4'h3: w_font = 7'h30;
      4'h4: w_font = 7'h19;  4'h5: w_font = 7'h12;
      4'h6: w_font = 7'h02;  4'h7: w_font = 7'h78;
      4'h8: w_font = 7'h00;  4'h9: w_font = 7'h10;
      4'hA: w_font = 7'h08;  4'hB: w_font = 7'h03;
      4'hC: w_font = 7'h46;  4'hD: w_font = 7'h21;
      4'hE: w_font = 7'h06;  4'hF: w_font = 7'h0E;
      default: w_font = 7'h7F;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scan_cnt <= '0;
      r_dig_idx  <= '0;
      r_seg      <= 8'hFF;
      r_dig      <= '1;
    end else begin
      if (r_scan_cnt == c_scan_last) begin
        r_scan_cnt <= '0;
        r_dig_idx  <= (r_dig_idx == c_dig_last) ? '0 : r_dig_idx + 1'b1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
      r_seg <= {~w_dp_lit, w_font};
      r_dig <= ~w_dig_oh;
    end
  end

  assign bus.seg     = r_seg;
  assign bus.dig     = r_dig;
  assign bus.sel_ch  = r_sel;
  assign bus.frozen  = (r_state == HOLD);
  assign bus.auto_on = r_auto;

endmodule

`default_nettype wire

// File: tb/tb_reg_view_monitor.sv
// ============================================================================
//  Module      : tb_reg_view_monitor
//  Description : Scoreboard bench for reg_view_monitor (short timing params).
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_reg_view_monitor;
  localparam int NUM_CH  = 5;
  localparam int NUM_DIG = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  reg_view_if #(.NUM_CH(NUM_CH), .NUM_DIG(NUM_DIG)) bus ();

  reg_view_monitor #(
    .NUM_CH(NUM_CH), .NUM_DIG(NUM_DIG), .DEB_CYCLES(4),
    .SCROLL_CYCLES(16), .SCAN_CYCLES(2)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct { int sel; int delta; } sel_exp_t;
  sel_exp_t    q_sel[$];
  int          total = 0, bad = 0, cyc = 0, cur_sel = 0;
  logic [7:0]  font [16];
  logic [15:0] exp_view;
  logic        exp_frz, exp_auto, check_disp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int dig_index(input logic [3:0] d);
    case (d)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input int idx);
    logic [7:0] s;
    s = font[exp_view[4*idx +: 4]];
    if ((idx == 0 && exp_frz) || (idx == 3 && exp_auto)) s[7] = 1'b0;
    return s;
  endfunction

  // Monitor: pops expected channel changes, checks each newly enabled digit.
  int         prev_sel = 0, last_chg = 0, prev_idx = 0, dig_age = 0;
  logic       have_dig = 1'b0;
  logic [3:0] prev_dig = 4'hF;
  always @(negedge clk) begin
    sel_exp_t e;
    int idx;
    cyc++;
    if (!reset) begin
      prev_sel = 0; last_chg = cyc; have_dig = 1'b0; dig_age = 0; prev_dig = 4'hF;
    end else begin
      if (int'(bus.sel_ch) != prev_sel) begin
        if (q_sel.size() == 0) begin
          check("unexpected_sel_change", bus.sel_ch, prev_sel);
        end else begin
          e = q_sel.pop_front();
          check("sel_value", bus.sel_ch, e.sel);
          if (e.delta >= 0) check("sel_interval", cyc - last_chg, e.delta);
        end
        prev_sel = int'(bus.sel_ch);
        last_chg = cyc;
      end
      dig_age++;
      if (bus.dig != prev_dig) begin
        idx = dig_index(bus.dig);
        if (check_disp) begin
          check("dig_onehot", (idx >= 0), 1);
          if (have_dig) begin
            check("dig_order", idx, (prev_idx + 1) % NUM_DIG);
            check("dig_dwell", dig_age, 2);
          end
          if (idx >= 0) check("seg_value", bus.seg, exp_seg(idx));
        end
        have_dig = (idx >= 0);
        prev_idx = idx;
        dig_age  = 0;
        prev_dig = bus.dig;
      end
    end
  end

  task automatic press(input logic [3:0] mask);
    @(posedge clk); #1 bus.btn_n = ~mask;
    repeat (10) @(posedge clk);
    #1 bus.btn_n = 4'hF;
    repeat (10) @(posedge clk);
  endtask

  task automatic step_next();
    cur_sel = (cur_sel + 1) % NUM_CH;
    q_sel.push_back('{cur_sel, -1});
    press(4'b0001);
  endtask

  task automatic step_prev();
    cur_sel = (cur_sel + NUM_CH - 1) % NUM_CH;
    q_sel.push_back('{cur_sel, -1});
    press(4'b0010);
  endtask

  task automatic wait_q();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (q_sel.size() == 0) break;
    end
    check("sel_queue_drain", q_sel.size(), 0);
  endtask

  task automatic set_all(input logic [15:0] v);
    for (int k = 0; k < NUM_CH; k++) bus.regs_in[16*k +: 16] = v;
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    check("rst_seg", bus.seg, 8'hFF);
    check("rst_dig", bus.dig, 4'hF);
    check("rst_sel", bus.sel_ch, 0);
    check("rst_frozen", bus.frozen, 0);
    check("rst_auto", bus.auto_on, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int waited;
    font = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    bus.btn_n = 4'hF;
    bus.regs_in = '0;
    bus.regs_in[15:0] = 16'h1234;
    exp_view = 16'h0; exp_frz = 1'b0; exp_auto = 1'b0; check_disp = 1'b0;

    // 1. reset state, then scan of channel 0
    repeat (3) @(posedge clk);
    check_reset_outputs();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check("first_dig", bus.dig, 4'b1110);
    exp_view = 16'h1234;
    repeat (3) @(posedge clk);
    #1 check_disp = 1'b1;
    repeat (20) @(posedge clk);
    #1 check_disp = 1'b0;

    // 2. bounced press, wrap forward, wrap backward
    q_sel.push_back('{1, -1}); cur_sel = 1;
    @(posedge clk); #1 bus.btn_n[0] = 1'b0;
    repeat (2) @(posedge clk); #1 bus.btn_n[0] = 1'b1;
    @(posedge clk);            #1 bus.btn_n[0] = 1'b0;
    repeat (10) @(posedge clk); #1 bus.btn_n[0] = 1'b1;
    repeat (10) @(posedge clk);
    wait_q();
    step_prev();
    repeat (5) step_next();
    wait_q();
    check("wrap_next_to_0", bus.sel_ch, 0);
    step_prev();
    wait_q();
    check("wrap_prev_to_4", bus.sel_ch, 4);

    // 3. next and prev together
    press(4'b0011);
    repeat (20) @(posedge clk);
    check("next_prev_same_cycle", bus.sel_ch, cur_sel);

    // 4. auto-scroll, manual step mid-interval
    set_all(16'hC0DE);
    q_sel.push_back('{0, -1});
    q_sel.push_back('{1, 16});
    q_sel.push_back('{2, 16});
    press(4'b1000);
    @(negedge clk);
    check("auto_on_set", bus.auto_on, 1);
    exp_view = 16'hC0DE; exp_auto = 1'b1; exp_frz = 1'b0;
    #1 check_disp = 1'b1;
    wait_q();
    repeat (3) @(posedge clk);
    q_sel.push_back('{3, -1});
    q_sel.push_back('{4, 16});
    cur_sel = 4;
    #1 bus.btn_n[0] = 1'b0;
    repeat (10) @(posedge clk); #1 bus.btn_n[0] = 1'b1;
    repeat (10) @(posedge clk);
    wait_q();
    #1 check_disp = 1'b0;
    press(4'b1000);
    @(negedge clk);
    check("auto_on_clear", bus.auto_on, 0);
    exp_auto = 1'b0;
    repeat (30) @(posedge clk);

    // 5. freeze snapshot of channel 2
    set_all(16'h0000);
    bus.regs_in[32 +: 16] = 16'h00AA;
    step_prev();
    step_prev();
    wait_q();
    exp_view = 16'h00AA;
    #1 check_disp = 1'b1;
    repeat (10) @(posedge clk);
    #1 check_disp = 1'b0;
    press(4'b0100);
    @(negedge clk);
    check("frozen_set", bus.frozen, 1);
    bus.regs_in[32 +: 16] = 16'h0055;
    exp_frz = 1'b1;
    repeat (4) @(posedge clk);
    #1 check_disp = 1'b1;
    repeat (20) @(posedge clk);
    #1 check_disp = 1'b0;
    bus.btn_n[2] = 1'b0;
    waited = 0;
    while (bus.frozen !== 1'b0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("unfreeze_seen", bus.frozen, 0);
    exp_view = 16'h0055; exp_frz = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    idx = dig_index(bus.dig);
    check("unfreeze_dig_valid", (idx >= 0), 1);
    if (idx >= 0) check("unfreeze_live_2cyc", bus.seg, exp_seg(idx));
    #1 bus.btn_n[2] = 1'b1;
    repeat (10) @(posedge clk);
    #1 check_disp = 1'b1;
    repeat (10) @(posedge clk);
    #1 check_disp = 1'b0;

    // 6. reset with prev held and auto on
    q_sel.push_back('{1, -1}); cur_sel = 1;
    @(posedge clk); #1 bus.btn_n = 4'b0101;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("auto_before_reset", bus.auto_on, 1);
    @(posedge clk); #1 bus.btn_n[3] = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_outputs();
    check("queue_before_reset", q_sel.size(), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    cur_sel = 0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("held_through_reset_no_pulse", bus.sel_ch, 0);
    check("auto_after_reset", bus.auto_on, 0);
    @(posedge clk); #1 bus.btn_n = 4'hF;
    repeat (10) @(posedge clk);
    step_next();
    wait_q();
    check("press_after_reset", bus.sel_ch, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
